block_dispatch: RTL

// Kernel-level block scheduler that sits directly upstream of the per-CU wave dispatchers.
// - Splits a launched grid into blocks and hands one block at a time to each free compute unit (CU).
// - For each CU it drives the block id, a one-cycle wave-dispatcher reset and an enable.
// - Counts the CUs' block_done reports and raises kernel done when every block has retired.

---
 rtl/block_dispatch.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/block_dispatch.sv
// Kernel block scheduler: splits a grid into blocks and feeds free CUs.
// Optional BLOCK_DISPATCH_PERF_EN adds a saturating RUN-cycle counter.
module block_dispatch #(
    parameter int NUM_CUS = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [31:0]              num_threads,
    input  logic [31:0]              block_dim,
    input  logic [NUM_CUS-1:0]       cu_block_done,
    output logic [NUM_CUS-1:0][31:0] cu_block_id,
    output logic [NUM_CUS-1:0]       cu_reset,
    output logic [NUM_CUS-1:0]       cu_enable,
    output logic                     busy,
    output logic                     done
`ifdef BLOCK_DISPATCH_PERF_EN
    ,
    output logic [31:0]              kernel_cycles
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] SL_FREE = 2'd0;
    localparam logic [1:0] SL_LOAD = 2'd1;
    localparam logic [1:0] SL_EXEC = 2'd2;

    logic [1:0]         state;
    logic [1:0]         slot [NUM_CUS];
    logic [31:0]        num_blocks;
    logic [31:0]        next_block;
    logic [31:0]        blocks_done;

    logic               accept;
    logic [31:0]        quot;
    logic [31:0]        rem;
    logic [31:0]        launch_blocks;
    logic [NUM_CUS-1:0] retire;
    logic [NUM_CUS-1:0] free_mask;
    logic [NUM_CUS-1:0] grant;
    logic [31:0]        retire_cnt;
    logic [31:0]        blocks_sum;
    logic               dispatch_ok;
    logic               finish;

    assign accept = start && (state != S_RUN);

    // A zero block_dim yields an empty grid rather than a divide fault.
    always_comb begin
        quot = '0;
        rem  = '0;
        if (block_dim != '0) begin
            quot = num_threads / block_dim;
            rem  = num_threads % block_dim;
        end
        launch_blocks = quot + {31'd0, |rem};
    end

    always_comb begin
        retire_cnt = '0;
        retire     = '0;
        free_mask  = '0;
        for (int i = 0; i < NUM_CUS; i++) begin
            retire[i]    = (state == S_RUN) && (slot[i] == SL_EXEC)
                           && cu_block_done[i];
            free_mask[i] = (slot[i] == SL_FREE);
            retire_cnt   = retire_cnt + 32'(retire[i]);
        end
    end

    // Lowest set bit of the free mask picks the lowest-index free CU.
    assign dispatch_ok = (state == S_RUN) && (next_block < num_blocks);
    assign grant = dispatch_ok
                   ? (free_mask & (~free_mask + NUM_CUS'(1)))
                   : '0;

    assign blocks_sum = blocks_done + retire_cnt;
    assign finish     = (state == S_RUN) && (blocks_sum == num_blocks);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            num_blocks  <= '0;
            next_block  <= '0;
            blocks_done <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        num_blocks  <= launch_blocks;
                        next_block  <= '0;
                        blocks_done <= '0;
                        state       <= (launch_blocks == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    blocks_done <= blocks_sum;
                    if (|grant) begin
                        next_block <= next_block + 32'd1;
                    end
                    if (finish) begin
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A CU retired on this edge still reads EXEC, so it cannot be granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CUS; i++) begin
                slot[i]        <= SL_FREE;
                cu_block_id[i] <= '1;
            end
        end else begin
            for (int i = 0; i < NUM_CUS; i++) begin
                unique case (slot[i])
                    SL_FREE: begin
                        if (grant[i]) begin
                            slot[i]        <= SL_LOAD;
                            cu_block_id[i] <= next_block;
                        end
                    end
                    SL_LOAD: slot[i] <= SL_EXEC;
                    SL_EXEC: begin
                        if (retire[i]) begin
                            slot[i]        <= SL_FREE;
                            cu_block_id[i] <= '1;
                        end
                    end
                    default: begin
                        slot[i]        <= SL_FREE;
                        cu_block_id[i] <= '1;
                    end
                endcase
            end
        end
    end

    always_comb begin
        cu_reset  = '0;
        cu_enable = '0;
        for (int i = 0; i < NUM_CUS; i++) begin
            cu_reset[i]  = (slot[i] == SL_LOAD);
            cu_enable[i] = (slot[i] == SL_EXEC);
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

`ifdef BLOCK_DISPATCH_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kernel_cycles <= '0;
        end else if (accept) begin
            kernel_cycles <= '0;
        end else if ((state == S_RUN) && (kernel_cycles != '1)) begin
            kernel_cycles <= kernel_cycles + 32'd1;
        end
    end
`endif

endmodule
